// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, execute redirect and decode handshake.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_fault,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_fault,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding word request, stale-response kill on redirect,
// buffered instruction handed to decode over valid/ready, sticky fault on misaligned target.
module if_fetch_chk (
    input logic clk,
    input logic rst_n,
    input logic imem_req,
    input logic inst_valid,
    input logic fetch_fault
);
    a_req_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_req && inst_valid));
    a_fault_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        fetch_fault |-> (!imem_req && !inst_valid));
endmodule

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    if_fetch_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] req_addr_r, req_addr_s;
    logic [31:0] inst_out_r, inst_out_s;
    logic [31:0] inst_pc_r, inst_pc_s;
    logic        kill_r, kill_s;
    logic        imem_req_r;
    logic        inst_valid_r;
    logic        fetch_fault_r;
    logic        bad_redirect_s;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    assign bad_redirect_s = bus.redirect_valid && misaligned(bus.redirect_pc);

    // Next-state and datapath update; misaligned redirect overrides everything else
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        req_addr_s = req_addr_r;
        inst_out_s = inst_out_r;
        inst_pc_s  = inst_pc_r;
        kill_s     = kill_r;

        if (bad_redirect_s) begin
            state_s = ST_FAULT;
            // Remember whether a response is still owed so it can be swallowed later
            case (state_r)
                ST_FETCH: kill_s = !bus.imem_rvalid;
                ST_FAULT: kill_s = kill_r && !bus.imem_rvalid;
                default:  kill_s = 1'b0;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_FETCH;
                    if (bus.redirect_valid) begin
                        pc_s       = bus.redirect_pc;
                        req_addr_s = bus.redirect_pc;
                    end else begin
                        req_addr_s = pc_r;
                    end
                end
                ST_FETCH: begin
                    if (bus.imem_rvalid) begin
                        if (kill_r || bus.redirect_valid) begin
                            kill_s = 1'b0;
                            if (bus.redirect_valid) begin
                                pc_s       = bus.redirect_pc;
                                req_addr_s = bus.redirect_pc;
                            end else begin
                                req_addr_s = pc_r;
                            end
                        end else begin
                            inst_out_s = bus.imem_rdata;
                            inst_pc_s  = req_addr_r;
                            pc_s       = req_addr_r + 32'd4;
                            state_s    = ST_VALID;
                        end
                    end else if (bus.redirect_valid) begin
                        // Address must stay put until the owed response returns
                        pc_s   = bus.redirect_pc;
                        kill_s = 1'b1;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_VALID: begin
                    if (bus.redirect_valid) begin
                        pc_s       = bus.redirect_pc;
                        req_addr_s = bus.redirect_pc;
                        state_s    = ST_FETCH;
                    end else if (bus.inst_ready) begin
                        req_addr_s = pc_r;
                        state_s    = ST_FETCH;
                    end else begin
                        state_s = ST_VALID;
                    end
                end
                ST_FAULT: begin
                    if (bus.redirect_valid) begin
                        pc_s       = bus.redirect_pc;
                        req_addr_s = bus.redirect_pc;
                        kill_s     = kill_r && !bus.imem_rvalid;
                        state_s    = ST_FETCH;
                    end else if (bus.imem_rvalid) begin
                        kill_s = 1'b0;
                    end else begin
                        state_s = ST_FAULT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    kill_s  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            req_addr_r    <= RESET_PC;
            inst_out_r    <= NOP_INST;
            inst_pc_r     <= RESET_PC;
            kill_r        <= 1'b0;
            imem_req_r    <= 1'b0;
            inst_valid_r  <= 1'b0;
            fetch_fault_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            req_addr_r    <= req_addr_s;
            inst_out_r    <= inst_out_s;
            inst_pc_r     <= inst_pc_s;
            kill_r        <= kill_s;
            imem_req_r    <= (state_s == ST_FETCH);
            inst_valid_r  <= (state_s == ST_VALID);
            fetch_fault_r <= (state_s == ST_FAULT);
        end
    end

    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = req_addr_r;
    assign bus.inst_valid  = inst_valid_r;
    assign bus.inst_out    = inst_out_r;
    assign bus.inst_pc     = inst_pc_r;
    assign bus.fetch_fault = fetch_fault_r;

    if_fetch_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req_r),
        .inst_valid  (inst_valid_r),
        .fetch_fault (fetch_fault_r)
    );

endmodule
